// File: rtl/video_in_wb_writer_if.sv
// Wishbone classic write-master bundle for the video capture writer.
// Signal names keep the bus's upper-case _O/_I naming so ports read as p_wb.ADR_O etc.
interface video_in_wb_writer_if;
  logic [31:0] ADR_O;
  logic [31:0] DAT_O;
  logic [3:0]  SEL_O;
  logic        STB_O;
  logic        CYC_O;
  logic        WE_O;
  logic        LOCK_O;
  logic [31:0] DAT_I;
  logic        ACK_I;
  logic        ERR_I;
  logic        RTY_I;

  modport master (
    output ADR_O, DAT_O, SEL_O, STB_O, CYC_O, WE_O, LOCK_O,
    input  DAT_I, ACK_I, ERR_I, RTY_I
  );

  modport slave (
    input  ADR_O, DAT_O, SEL_O, STB_O, CYC_O, WE_O, LOCK_O,
    output DAT_I, ACK_I, ERR_I, RTY_I
  );
endinterface

// File: rtl/video_in_wb_writer.sv
// Camera capture into a ping-pong byte window, drained to RAM as 32-bit Wishbone
// single writes from a per-frame base address; irq pulses once the frame is committed.
module video_in_wb_writer #(
  parameter int          WINDOW_SIZE = 64,
  parameter int          BLOCK_SIZE  = 32,
  parameter logic [31:0] ADDR_RESET  = 32'h41000000
) (
  input  logic                        p_clk,
  input  logic                        p_resetn,
  input  logic                        frame_valid,
  input  logic                        line_valid,
  input  logic [7:0]                  pixel_in,
  input  logic [31:0]                 cfg_base,
  input  logic                        cfg_enable,
  output logic                        irq,
  output logic                        overflow,
  output logic                        wb_err,
  video_in_wb_writer_if.master        p_wb
);

  localparam int PTR_W  = $clog2(BLOCK_SIZE + 1);
  localparam int WIN_AW = $clog2(WINDOW_SIZE);
  localparam logic [PTR_W-1:0] BLOCK_LEN = PTR_W'(BLOCK_SIZE);

  typedef enum logic [1:0] {C_IDLE, C_CAPTURE, C_FLUSH} cap_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT}      wr_state_t;

  cap_state_t cap_state, cap_next;
  wr_state_t  wr_state, wr_next;

  logic             fv_d;
  logic             fv_rise, fv_fall, pix_vld;
  logic             frame_start, flush_mark, flush_done;

  logic [7:0]       buf_mem [WINDOW_SIZE];
  logic [1:0]       half_full;
  logic [PTR_W-1:0] half_bytes [2];
  logic             cap_half;
  logic [PTR_W-1:0] fill_ptr;
  logic [WIN_AW-1:0] cap_idx;

  logic             wr_half;
  logic [PTR_W-1:0] wr_off;
  logic [31:0]      address;
  logic [31:0]      rd_word;

  logic             term_ok, term_rty, last_word, blk_done;
  logic             pix_in_cap, target_busy, pix_accept, pix_drop, half_wrap;
  logic             unused_dat;

  assign unused_dat = ^p_wb.DAT_I;

  assign p_wb.SEL_O  = 4'hF;
  assign p_wb.LOCK_O = 1'b0;

  assign fv_rise     = frame_valid & ~fv_d;
  assign fv_fall     = ~frame_valid & fv_d;
  assign pix_vld     = frame_valid & line_valid;
  assign frame_start = (cap_state == C_IDLE) && fv_rise && cfg_enable;

  // ERR outranks ACK, which outranks RTY; ERR terminates like ACK.
  assign term_ok   = (wr_state == W_WAIT) && (p_wb.ACK_I || p_wb.ERR_I);
  assign term_rty  = (wr_state == W_WAIT) && !p_wb.ACK_I && !p_wb.ERR_I && p_wb.RTY_I;
  assign last_word = (int'(wr_off) + 4) >= int'(half_bytes[wr_half]);
  assign blk_done  = term_ok && last_word;

  // A half being released this very cycle is already free for capture.
  assign pix_in_cap  = (cap_state == C_CAPTURE) && pix_vld;
  assign target_busy = half_full[cap_half] && !(blk_done && (wr_half == cap_half));
  assign pix_accept  = pix_in_cap && !target_busy;
  assign pix_drop    = pix_in_cap && target_busy;
  assign half_wrap   = pix_accept && (fill_ptr == BLOCK_LEN - PTR_W'(1));
  assign flush_mark  = (cap_state == C_CAPTURE) && fv_fall && (fill_ptr != '0);
  assign flush_done  = (cap_state == C_FLUSH) && (half_full == 2'b00) &&
                       (wr_state == W_IDLE) && !p_wb.CYC_O;

  assign cap_idx = WIN_AW'(int'(cap_half) * BLOCK_SIZE + int'(fill_ptr));

  always_comb begin
    cap_next = cap_state;
    unique case (cap_state)
      C_IDLE:    if (frame_start) cap_next = C_CAPTURE;
      C_CAPTURE: if (fv_fall)     cap_next = C_FLUSH;
      C_FLUSH:   if (flush_done)  cap_next = C_IDLE;
      default:                    cap_next = C_IDLE;
    endcase
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE: if (half_full[wr_half]) wr_next = W_REQ;
      W_REQ:  wr_next = W_WAIT;
      W_WAIT: begin
        if (term_ok)       wr_next = last_word ? W_IDLE : W_REQ;
        else if (term_rty) wr_next = W_REQ;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  // Bytes past the end of a partial half read back as zero padding.
  always_comb begin
    logic [WIN_AW-1:0] idx;
    idx     = '0;
    rd_word = '0;
    for (int k = 0; k < 4; k++) begin
      idx = WIN_AW'(int'(wr_half) * BLOCK_SIZE + int'(wr_off) + k);
      if ((int'(wr_off) + k) < int'(half_bytes[wr_half]))
        rd_word[8*k +: 8] = buf_mem[idx];
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      cap_state <= C_IDLE;
      wr_state  <= W_IDLE;
      fv_d      <= 1'b0;
    end else begin
      cap_state <= cap_next;
      wr_state  <= wr_next;
      fv_d      <= frame_valid;
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      cap_half <= 1'b0;
      fill_ptr <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= flush_done;
      if (frame_start) begin
        cap_half <= 1'b0;
        fill_ptr <= '0;
        overflow <= 1'b0;
      end else begin
        if (pix_drop) overflow <= 1'b1;
        if (half_wrap) begin
          cap_half <= ~cap_half;
          fill_ptr <= '0;
        end else if (pix_accept) begin
          fill_ptr <= fill_ptr + PTR_W'(1);
        end else if (flush_mark) begin
          fill_ptr <= '0;
        end
      end
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      half_full <= 2'b00;
    end else begin
      if (blk_done)   half_full[wr_half]  <= 1'b0;
      if (half_wrap)  half_full[cap_half] <= 1'b1;
      if (flush_mark) half_full[cap_half] <= 1'b1;
    end
  end

  always_ff @(posedge p_clk) begin
    if (half_wrap)       half_bytes[cap_half] <= BLOCK_LEN;
    else if (flush_mark) half_bytes[cap_half] <= fill_ptr;
    if (pix_accept)      buf_mem[cap_idx]     <= pixel_in;
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      wr_half     <= 1'b0;
      wr_off      <= '0;
      address     <= ADDR_RESET;
      wb_err      <= 1'b0;
      p_wb.ADR_O  <= '0;
      p_wb.DAT_O  <= '0;
      p_wb.STB_O  <= 1'b0;
      p_wb.CYC_O  <= 1'b0;
      p_wb.WE_O   <= 1'b0;
    end else begin
      if (frame_start) begin
        address <= cfg_base;
        wr_half <= 1'b0;
        wr_off  <= '0;
        wb_err  <= 1'b0;
      end
      if (wr_state == W_REQ) begin
        p_wb.ADR_O <= address;
        p_wb.DAT_O <= rd_word;
        p_wb.STB_O <= 1'b1;
        p_wb.CYC_O <= 1'b1;
        p_wb.WE_O  <= 1'b1;
      end else if (term_ok || term_rty) begin
        p_wb.STB_O <= 1'b0;
        p_wb.CYC_O <= 1'b0;
        p_wb.WE_O  <= 1'b0;
        if (term_ok) begin
          address <= address + 32'd4;
          if (p_wb.ERR_I) wb_err <= 1'b1;
          if (last_word) begin
            wr_off  <= '0;
            wr_half <= ~wr_half;
          end else begin
            wr_off <= wr_off + PTR_W'(4);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_video_in_wb_writer.sv
// Bench for video_in_wb_writer: random and directed frames against a byte-stream
// reference model, with a negedge-driven Wishbone slave that can stall, ERR or RTY.
module tb_video_in_wb_writer;
  logic        p_clk = 1'b0;
  logic        p_resetn = 1'b0;
  logic        frame_valid = 1'b0;
  logic        line_valid = 1'b0;
  logic [7:0]  pixel_in = 8'h00;
  logic [31:0] cfg_base = 32'h0;
  logic        cfg_enable = 1'b0;
  logic        irq, overflow, wb_err;

  video_in_wb_writer_if wb();

  video_in_wb_writer dut (
    .p_clk       (p_clk),
    .p_resetn    (p_resetn),
    .frame_valid (frame_valid),
    .line_valid  (line_valid),
    .pixel_in    (pixel_in),
    .cfg_base    (cfg_base),
    .cfg_enable  (cfg_enable),
    .irq         (irq),
    .overflow    (overflow),
    .wb_err      (wb_err),
    .p_wb        (wb)
  );

  always #5 p_clk = ~p_clk;

  int total = 0;
  int bad = 0;
  int irq_cnt = 0;
  int ack_delay = 0, first_delay = 0, err_at = -1, rty_at = -1;
  int term_idx = 0, wait_cnt = 0;
  bit rty_done = 1'b0, rty_checked = 1'b0;
  logic [31:0] rty_adr = 32'h0;
  logic [7:0]  pix_q[$];
  logic [31:0] wr_adr_q[$];
  logic [31:0] wr_dat_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge p_clk) if (p_resetn && irq) irq_cnt++;

  // Wishbone slave: decides the termination for the next rising edge.
  always @(negedge p_clk) begin
    wb.ACK_I = 1'b0;
    wb.ERR_I = 1'b0;
    wb.RTY_I = 1'b0;
    if (p_resetn && wb.STB_O && wb.CYC_O) begin
      if (wait_cnt < ((term_idx == 0) ? first_delay : ack_delay)) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (term_idx == err_at) begin
          wb.ERR_I = 1'b1;
          term_idx++;
        end else if (term_idx == rty_at && !rty_done) begin
          wb.RTY_I = 1'b1;
          rty_done = 1'b1;
          rty_adr  = wb.ADR_O;
        end else begin
          if (rty_done && !rty_checked) begin
            check_val("rty_same_adr", 64'(wb.ADR_O), 64'(rty_adr));
            rty_checked = 1'b1;
          end
          check_val("we_sel_lock", 64'({wb.WE_O, wb.SEL_O, wb.LOCK_O}), 64'(6'b1_1111_0));
          wr_adr_q.push_back(wb.ADR_O);
          wr_dat_q.push_back(wb.DAT_O);
          wb.ACK_I = 1'b1;
          term_idx++;
        end
      end
    end
  end

  task automatic setup_slave(input int d, input int fd, input int e, input int r);
    ack_delay = d; first_delay = fd; err_at = e; rty_at = r;
    term_idx = 0; wait_cnt = 0; rty_done = 1'b0; rty_checked = 1'b0;
    wr_adr_q.delete(); wr_dat_q.delete(); pix_q.delete();
  endtask

  task automatic drive_frame(input int w, input int h, input int hblank, input bit rnd,
                             input int start, input bit drop_en);
    int cnt;
    cnt = start;
    frame_valid = 1'b1;
    line_valid  = 1'b0;
    repeat (3) @(negedge p_clk);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        pixel_in   = rnd ? 8'($urandom_range(0, 255)) : 8'(cnt);
        cnt++;
        line_valid = 1'b1;
        pix_q.push_back(pixel_in);
        @(negedge p_clk);
      end
      line_valid = 1'b0;
      if (drop_en) cfg_enable = 1'b0;
      repeat (hblank) @(negedge p_clk);
    end
    frame_valid = 1'b0;
    @(negedge p_clk);
    cfg_enable = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int target);
    int c;
    c = 0;
    while (irq_cnt < target && c < 20000) begin
      @(negedge p_clk);
      c++;
    end
    repeat (10) @(negedge p_clk);
    check_val({tag, "_irq"}, 64'(irq_cnt), 64'(target));
  endtask

  // Reference: the frame's bytes, packed little-endian into words, zero padded,
  // written to consecutive addresses from base; an ERR'd word is never committed.
  task automatic compare_writes(input string tag, input logic [31:0] base, input int skip);
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic [31:0] word;
    int n, nw, m;
    n  = pix_q.size();
    nw = (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4*i + k < n) word[8*k +: 8] = pix_q[4*i + k];
      if (i != skip) begin
        exp_adr.push_back(base + 32'(4*i));
        exp_dat.push_back(word);
      end
    end
    check_val({tag, "_count"}, 64'(wr_adr_q.size()), 64'(exp_adr.size()));
    m = (wr_adr_q.size() < exp_adr.size()) ? wr_adr_q.size() : exp_adr.size();
    for (int i = 0; i < m; i++) begin
      check_val({tag, "_adr"}, 64'(wr_adr_q[i]), 64'(exp_adr[i]));
      check_val({tag, "_dat"}, 64'(wr_dat_q[i]), 64'(exp_dat[i]));
    end
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int hblank,
                           input bit rnd, input int start, input logic [31:0] base,
                           input bit drop_en, input int skip);
    int target;
    target   = irq_cnt + 1;
    cfg_base = base;
    drive_frame(w, h, hblank, rnd, start, drop_en);
    wait_done(tag, target);
    compare_writes(tag, base, skip);
    check_val({tag, "_overflow"}, 64'(overflow), 64'(0));
    check_val({tag, "_wb_err"}, 64'(wb_err), (skip >= 0) ? 64'(1) : 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    int target, c;
    wb.ACK_I = 1'b0; wb.ERR_I = 1'b0; wb.RTY_I = 1'b0; wb.DAT_I = 32'h0;
    repeat (3) @(negedge p_clk);
    check_val("rst_stb_cyc_we", 64'({wb.STB_O, wb.CYC_O, wb.WE_O}), 64'(0));
    check_val("rst_flags", 64'({irq, overflow, wb_err}), 64'(0));
    check_val("rst_adr", 64'(wb.ADR_O), 64'(0));
    check_val("rst_dat", 64'(wb.DAT_O), 64'(0));
    check_val("rst_sel_lock", 64'({wb.SEL_O, wb.LOCK_O}), 64'(5'b1111_0));
    p_resetn   = 1'b1;
    cfg_enable = 1'b1;
    repeat (2) @(negedge p_clk);

    setup_slave(0, 0, -1, -1);
    run_frame("ramp8x2", 8, 2, 4, 1'b0, 0, 32'h4100_0000, 1'b0, -1);

    setup_slave(0, 0, -1, -1);
    run_frame("five", 5, 1, 4, 1'b0, 8'hA1, 32'h4100_0000, 1'b0, -1);

    for (int i = 0; i < 6; i++) begin
      setup_slave($urandom_range(0, 1), 0, -1, -1);
      b = $urandom() & 32'hFFFF_FFFC;
      run_frame("rand", $urandom_range(1, 24), $urandom_range(1, 4), $urandom_range(4, 10),
                1'b1, 0, b, (i == 3), -1);
    end

    setup_slave(0, 0, -1, -1);
    run_frame("wrap", 40, 1, 4, 1'b1, 0, 32'hFFFF_FFF0, 1'b0, -1);

    setup_slave(0, 0, 2, 3);
    run_frame("err_rty", 32, 1, 4, 1'b0, 16, 32'h4100_0100, 1'b0, 2);
    if (wr_adr_q.size() > 0)
      check_val("err_rty_last_adr", 64'(wr_adr_q[wr_adr_q.size()-1]), 64'(32'h4100_0100 + 32'd28));
    else
      check_val("err_rty_last_adr", 64'(0), 64'(32'h4100_011C));

    setup_slave(0, 0, -1, -1);
    target     = irq_cnt;
    cfg_enable = 1'b0;
    cfg_base   = 32'h4200_0000;
    frame_valid = 1'b0;
    @(negedge p_clk);
    cfg_enable = 1'b0;
    drive_frame(16, 2, 4, 1'b1, 0, 1'b0);
    repeat (100) @(negedge p_clk);
    check_val("disabled_irq", 64'(irq_cnt), 64'(target));
    check_val("disabled_writes", 64'(wr_adr_q.size()), 64'(0));

    setup_slave(0, 200, -1, -1);
    target   = irq_cnt + 1;
    cfg_base = 32'h4300_0000;
    drive_frame(80, 4, 10, 1'b1, 0, 1'b0);
    wait_done("ovf", target);
    check_val("ovf_flag", 64'(overflow), 64'(1));
    check_val("ovf_later_words", 64'(wr_adr_q.size() > 16), 64'(1));

    setup_slave(1, 0, -1, -1);
    run_frame("after_ovf", 20, 3, 6, 1'b1, 0, 32'h4400_0000, 1'b0, -1);

    setup_slave(2000, 2000, -1, -1);
    target   = irq_cnt;
    cfg_base = 32'h4500_0000;
    frame_valid = 1'b1;
    repeat (3) @(negedge p_clk);
    for (int x = 0; x < 40; x++) begin
      line_valid = 1'b1;
      pixel_in   = 8'(x);
      @(negedge p_clk);
    end
    line_valid = 1'b0;
    c = 0;
    while (!wb.STB_O && c < 200) begin
      @(negedge p_clk);
      c++;
    end
    check_val("rstmid_stb_seen", 64'(wb.STB_O), 64'(1));
    p_resetn = 1'b0;
    #1;
    check_val("rstmid_stb_cyc", 64'({wb.STB_O, wb.CYC_O}), 64'(0));
    frame_valid = 1'b0;
    repeat (2) @(negedge p_clk);
    p_resetn = 1'b1;
    repeat (100) @(negedge p_clk);
    check_val("rstmid_no_irq", 64'(irq_cnt), 64'(target));
    check_val("rstmid_no_writes", 64'(wr_adr_q.size()), 64'(0));
    check_val("rstmid_idle_bus", 64'({wb.STB_O, wb.CYC_O, overflow}), 64'(0));

    setup_slave(0, 0, -1, -1);
    run_frame("recover", 12, 2, 5, 1'b1, 0, 32'h4600_0000, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
